fpu_share_arb: RTL and testbench

//  Shares the single FPU between NREQ requesters (core FPU slot, future second core/DMA).

---
 rtl/fpu_share_arb_pkg.sv | 22 ++
 rtl/fpu_share_arb_if.sv | 42 ++++
 rtl/fpu_share_arb_tag_fifo.sv | 52 +++++
 rtl/fpu_share_arb.sv | 154 +++++++++++++++
 tb/tb_fpu_share_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_share_arb_pkg.sv
// Shared constants and types for the FPU sharing arbiter.
// Covers FPU field widths, error-vector bit positions and the issue FSM encoding.
package fpu_share_arb_pkg;

  localparam int OPE_W     = 4;
  localparam int DATA_W    = 32;
  localparam int FPU_ERR_W = 3;
  localparam int ERR_W     = 8;
  localparam int ERR_LOST  = 7;
  localparam int ERR_OVF   = 6;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } issue_state_t;

  // Tag width for n requesters; a single requester still carries a 1-bit tag.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_share_arb_if.sv
// Requester-side and FPU-side valid/ready signals of the FPU sharing arbiter.
// The slave modport is the arbiter's view; the master modport is the view of its surroundings.
interface fpu_share_arb_if
  import fpu_share_arb_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [OPE_W*NREQ-1:0]  rq_ope;
  logic [DATA_W*NREQ-1:0] rq_in1;
  logic [DATA_W*NREQ-1:0] rq_in2;
  logic [NREQ-1:0]        rq_in_vld;
  logic [NREQ-1:0]        rq_in_rdy;
  logic [DATA_W-1:0]      rq_out_data;
  logic [NREQ-1:0]        rq_out_vld;
  logic [NREQ-1:0]        rq_out_rdy;

  logic [OPE_W-1:0]       f_ope_data;
  logic [DATA_W-1:0]      f_in1_data;
  logic [DATA_W-1:0]      f_in2_data;
  logic                   f_in_vld;
  logic                   f_in_rdy;
  logic [DATA_W-1:0]      f_out_data;
  logic                   f_out_vld;
  logic                   f_out_rdy;
  logic [FPU_ERR_W-1:0]   f_err;

  modport slave (
    input  rq_ope, rq_in1, rq_in2, rq_in_vld, rq_out_rdy,
    input  f_in_rdy, f_out_data, f_out_vld, f_err,
    output rq_in_rdy, rq_out_data, rq_out_vld,
    output f_ope_data, f_in1_data, f_in2_data, f_in_vld, f_out_rdy
  );

  modport master (
    output rq_ope, rq_in1, rq_in2, rq_in_vld, rq_out_rdy,
    output f_in_rdy, f_out_data, f_out_vld, f_err,
    input  rq_in_rdy, rq_out_data, rq_out_vld,
    input  f_ope_data, f_in1_data, f_in2_data, f_in_vld, f_out_rdy
  );

endinterface

// File: rtl/fpu_share_arb_tag_fifo.sv
// In-order FIFO of requester tags, one entry per FPU operation in flight.
// A push while full is dropped and reported on ovf.
module fpu_share_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_tag,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic         ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign ovf     = push && full;
  assign head    = mem[rd_ptr];

  // NOTE: tag storage has no reset; count/empty guard every read, so contents before the first push are never used.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fpu_share_arb.sv
// Shares one FPU between NREQ requesters: round-robin issue arbiter with a 2-state issue FSM,
// plus an in-order tag FIFO that routes each result back to the requester that issued it.
module fpu_share_arb
  import fpu_share_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  fpu_share_arb_if.slave   bus,
  output logic [ERR_W-1:0] err
);

  localparam int TW = tag_w(NREQ);

  issue_state_t      state;
  logic [TW-1:0]     rr_ptr;
  logic [OPE_W-1:0]  f_ope_q;
  logic [DATA_W-1:0] f_in1_q;
  logic [DATA_W-1:0] f_in2_q;
  logic              f_in_vld_q;

  logic              grant_any;
  logic [TW-1:0]     grant_idx;
  int                idx;
  logic [NREQ-1:0]   rq_in_rdy_c;
  logic [OPE_W-1:0]  sel_ope;
  logic [DATA_W-1:0] sel_in1;
  logic [DATA_W-1:0] sel_in2;

  logic              full;
  logic              empty;
  logic [TW-1:0]     head;
  logic              pop;
  logic              ovf;
  logic              head_rdy;
  logic [NREQ-1:0]   rq_out_vld_c;
  logic              f_out_rdy_c;

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!rst && state == ST_IDLE && !full) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!grant_any && bus.rq_in_vld[idx]) begin
          grant_any = 1'b1;
          grant_idx = TW'(idx);
        end
      end
    end
  end

  always_comb begin
    rq_in_rdy_c = '0;
    sel_ope     = '0;
    sel_in1     = '0;
    sel_in2     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && grant_idx == TW'(i)) begin
        rq_in_rdy_c[i] = 1'b1;
        sel_ope        = bus.rq_ope[OPE_W*i +: OPE_W];
        sel_in1        = bus.rq_in1[DATA_W*i +: DATA_W];
        sel_in2        = bus.rq_in2[DATA_W*i +: DATA_W];
      end
    end
  end

  // Operands are captured at the grant and held untouched until the FPU accepts them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      f_ope_q    <= '0;
      f_in1_q    <= '0;
      f_in2_q    <= '0;
      f_in_vld_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            f_ope_q    <= sel_ope;
            f_in1_q    <= sel_in1;
            f_in2_q    <= sel_in2;
            f_in_vld_q <= 1'b1;
            rr_ptr     <= TW'((int'(grant_idx) + 1) % NREQ);
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.f_in_rdy) begin
            f_in_vld_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fpu_share_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant_any),
    .push_tag (grant_idx),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head),
    .ovf      (ovf)
  );

  always_comb begin
    rq_out_vld_c = '0;
    head_rdy     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (head == TW'(i)) begin
        rq_out_vld_c[i] = bus.f_out_vld && !empty;
        head_rdy        = bus.rq_out_rdy[i];
      end
    end
  end

  // With no owner on record the result is accepted anyway so the FPU never wedges.
  assign f_out_rdy_c = empty || head_rdy;
  assign pop         = bus.f_out_vld && f_out_rdy_c && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      if (bus.f_out_vld && empty) err[ERR_LOST] <= 1'b1;
      if (ovf)                    err[ERR_OVF]  <= 1'b1;
      if (bus.f_out_vld && f_out_rdy_c)
        err[FPU_ERR_W-1:0] <= err[FPU_ERR_W-1:0] | bus.f_err;
    end
  end

  assign bus.rq_in_rdy   = rq_in_rdy_c;
  assign bus.rq_out_data = bus.f_out_data;
  assign bus.rq_out_vld  = rq_out_vld_c;
  assign bus.f_out_rdy   = f_out_rdy_c;
  assign bus.f_ope_data  = f_ope_q;
  assign bus.f_in1_data  = f_in1_q;
  assign bus.f_in2_data  = f_in2_q;
  assign bus.f_in_vld    = f_in_vld_q;

endmodule

// File: tb/tb_fpu_share_arb.sv
// Self-checking bench for fpu_share_arb: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the arbiter.
module tb_fpu_share_arb;
  import fpu_share_arb_pkg::*;

  localparam int NREQ      = 2;
  localparam int TAG_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [ERR_W-1:0] err;

  fpu_share_arb_if #(.NREQ(NREQ)) bus ();

  fpu_share_arb #(
    .NREQ      (NREQ),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owners of in-flight ops in issue order, RR pointer, op waiting at the FPU.
  int          m_q[$];
  int          m_rr;
  bit          m_busy;
  logic [3:0]  m_ope;
  logic [31:0] m_in1;
  logic [31:0] m_in2;
  logic [7:0]  m_err;
  int          fpu_pending;

  logic [NREQ-1:0] obs_rdy;
  logic [NREQ-1:0] obs_ovld;
  logic            obs_fvld;
  logic            obs_frdy;
  logic [3:0]      obs_ope;
  logic [31:0]     obs_in1;
  logic [31:0]     obs_in2;
  logic [31:0]     obs_odata;
  logic [7:0]      obs_err;

  logic [NREQ-1:0] grants[4];
  int              ngr;
  logic [3:0]      t_ope;
  logic [31:0]     t_in1;
  logic [31:0]     t_in2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr        = 0;
    m_busy      = 1'b0;
    m_ope       = '0;
    m_in1       = '0;
    m_in2       = '0;
    m_err       = '0;
    fpu_pending = 0;
  endtask

  task automatic drive_quiet();
    bus.rq_ope     = '0;
    bus.rq_in1     = '0;
    bus.rq_in2     = '0;
    bus.rq_in_vld  = '0;
    bus.rq_out_rdy = '0;
    bus.f_in_rdy   = 1'b0;
    bus.f_out_data = '0;
    bus.f_out_vld  = 1'b0;
    bus.f_err      = '0;
  endtask

  task automatic set_req(input int i, input logic [3:0] ope, input logic [31:0] a, input logic [31:0] b);
    bus.rq_ope[4*i +: 4]  = ope;
    bus.rq_in1[32*i +: 32] = a;
    bus.rq_in2[32*i +: 32] = b;
  endtask

  // Enter at posedge+1 with inputs set; compare mid-cycle, advance the model at the edge.
  task automatic step();
    int g;
    int h;
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_ovld;
    logic e_frdy;
    #3;
    g = -1;
    if (!m_busy && m_q.size() < TAG_DEPTH)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bus.rq_in_vld[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    e_ovld = '0;
    e_frdy = 1'b1;
    if (m_q.size() > 0) begin
      h         = m_q[0];
      e_ovld[h] = bus.f_out_vld;
      e_frdy    = bus.rq_out_rdy[h];
    end
    obs_rdy   = bus.rq_in_rdy;
    obs_ovld  = bus.rq_out_vld;
    obs_fvld  = bus.f_in_vld;
    obs_frdy  = bus.f_out_rdy;
    obs_ope   = bus.f_ope_data;
    obs_in1   = bus.f_in1_data;
    obs_in2   = bus.f_in2_data;
    obs_odata = bus.rq_out_data;
    obs_err   = err;
    check("rq_in_rdy", obs_rdy, e_rdy);
    check("f_in_vld", obs_fvld, m_busy);
    check("f_ope", obs_ope, m_ope);
    check("f_in1", obs_in1, m_in1);
    check("f_in2", obs_in2, m_in2);
    check("rq_out_vld", obs_ovld, e_ovld);
    check("rq_out_data", obs_odata, bus.f_out_data);
    check("f_out_rdy", obs_frdy, e_frdy);
    check("err", obs_err, m_err);
    @(posedge clk);
    if (bus.f_out_vld && e_frdy) begin
      if (m_q.size() == 0) m_err[ERR_LOST] = 1'b1;
      else begin
        void'(m_q.pop_front());
        if (fpu_pending > 0) fpu_pending--;
      end
      m_err[2:0] = m_err[2:0] | bus.f_err;
    end
    if (m_busy && bus.f_in_rdy) begin
      m_busy = 1'b0;
      fpu_pending++;
    end
    if (g >= 0) begin
      m_busy = 1'b1;
      m_ope  = bus.rq_ope[4*g +: 4];
      m_in1  = bus.rq_in1[32*g +: 32];
      m_in2  = bus.rq_in2[32*g +: 32];
      m_q.push_back(g);
      m_rr   = (g + 1) % NREQ;
    end
    #1;
  endtask

  task automatic apply_reset();
    drive_quiet();
    rst           = 1'b1;
    bus.rq_in_vld = '1;
    #2;
    check("rst_rq_in_rdy", bus.rq_in_rdy, 0);
    check("rst_f_in_vld", bus.f_in_vld, 0);
    check("rst_f_ope", bus.f_ope_data, 0);
    check("rst_f_in1", bus.f_in1_data, 0);
    check("rst_err", err, 0);
    check("rst_fifo_empty", bus.f_out_rdy, 1);
    bus.rq_in_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    drive_quiet();
    model_reset();
    #1;

    // 1: single op from requester 0
    apply_reset();
    set_req(0, 4'h0, 32'h3f800000, 32'h40000000);
    bus.rq_in_vld = 2'b01;
    step();
    check("t1_grant", obs_rdy, 2'b01);
    bus.rq_in_vld = '0;
    bus.f_in_rdy  = 1'b1;
    step();
    check("t1_f_in_vld", obs_fvld, 1);
    check("t1_f_in1", obs_in1, 32'h3f800000);
    check("t1_f_in2", obs_in2, 32'h40000000);
    bus.f_in_rdy   = 1'b0;
    bus.f_out_vld  = 1'b1;
    bus.f_out_data = 32'h40400000;
    bus.rq_out_rdy = 2'b01;
    step();
    check("t1_out_vld", obs_ovld, 2'b01);
    check("t1_out_data", obs_odata, 32'h40400000);
    bus.f_out_vld  = 1'b0;
    bus.rq_out_rdy = '0;
    step();
    check("t1_fifo_empty", obs_frdy, 1);
    check("t1_f_in_vld_low", obs_fvld, 0);

    // 2: both requesters always valid, FPU always ready
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 3), $urandom, $urandom);
    bus.rq_in_vld  = 2'b11;
    bus.f_in_rdy   = 1'b1;
    bus.rq_out_rdy = 2'b11;
    ngr = 0;
    for (int i = 0; i < 4; i++) grants[i] = '0;
    for (int c = 0; c < 12; c++) begin
      bus.f_out_vld  = (fpu_pending > 0);
      bus.f_out_data = $urandom;
      step();
      if (obs_rdy != '0 && ngr < 4) begin
        grants[ngr] = obs_rdy;
        ngr++;
      end
    end
    check("t2_grant0", grants[0], 2'b01);
    check("t2_grant1", grants[1], 2'b10);
    check("t2_grant2", grants[2], 2'b01);
    check("t2_grant3", grants[3], 2'b10);

    // 3: FPU stalls its input for 5 cycles while requesters keep changing operands
    apply_reset();
    t_ope = 4'h9;
    t_in1 = 32'hdeadbeef;
    t_in2 = 32'h12345678;
    set_req(0, t_ope, t_in1, t_in2);
    set_req(1, 4'h2, 32'h1, 32'h2);
    bus.rq_in_vld = 2'b11;
    step();
    check("t3_grant", obs_rdy, 2'b01);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), $urandom, $urandom);
      step();
      check("t3_stall_vld", obs_fvld, 1);
      check("t3_stall_ope", obs_ope, t_ope);
      check("t3_stall_in1", obs_in1, t_in1);
      check("t3_stall_in2", obs_in2, t_in2);
      check("t3_stall_no_rdy", obs_rdy, 0);
    end
    bus.f_in_rdy = 1'b1;
    step();
    step();
    check("t3_next_grant", obs_rdy, 2'b10);
    bus.rq_in_vld = '0;
    step();

    // 4: results stalled, tag FIFO fills after TAG_DEPTH ops
    apply_reset();
    bus.rq_in_vld  = 2'b11;
    bus.f_in_rdy   = 1'b1;
    bus.rq_out_rdy = 2'b11;
    ngr = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), $urandom, $urandom);
      step();
      if (obs_rdy != '0) ngr++;
    end
    check("t4_accepted", ngr, TAG_DEPTH);
    step();
    check("t4_fifth_waits", obs_rdy, 0);
    bus.f_out_vld  = 1'b1;
    bus.f_out_data = 32'hc0ffee00;
    step();
    check("t4_pop0_owner", obs_ovld, 2'b01);
    bus.f_out_data = 32'hc0ffee01;
    step();
    check("t4_fifth_accept", obs_rdy, 2'b01);
    check("t4_pop1_owner", obs_ovld, 2'b10);
    bus.f_out_vld = 1'b0;
    step();
    step();
    check("t4_refill", obs_rdy, 2'b10);
    step();
    step();
    check("t4_full_again", obs_rdy, 0);

    // 5: orphan result, then FPU exception flags
    apply_reset();
    bus.f_out_vld = 1'b1;
    step();
    check("t5_drain_rdy", obs_frdy, 1);
    check("t5_no_out_vld", obs_ovld, 0);
    bus.f_out_vld = 1'b0;
    step();
    check("t5_err_lost", obs_err, 8'h80);
    bus.rq_in_vld = 2'b01;
    bus.f_in_rdy  = 1'b1;
    step();
    bus.rq_in_vld = '0;
    step();
    bus.f_out_vld  = 1'b1;
    bus.f_err      = 3'b010;
    bus.rq_out_rdy = 2'b01;
    step();
    bus.f_out_vld = 1'b0;
    bus.f_err     = '0;
    step();
    check("t5_err_fpu", obs_err, 8'h82);
    step();
    check("t5_err_sticky", obs_err, 8'h82);

    // 6: async reset in ISSUE with two tags outstanding
    apply_reset();
    bus.f_out_vld = 1'b1;
    step();
    bus.f_out_vld = 1'b0;
    bus.rq_in_vld = 2'b01;
    bus.f_in_rdy  = 1'b1;
    step();
    bus.rq_in_vld = '0;
    step();
    bus.rq_in_vld = 2'b10;
    bus.f_in_rdy  = 1'b0;
    step();
    bus.rq_in_vld = '0;
    step();
    check("t6_pre_vld", obs_fvld, 1);
    check("t6_pre_nonempty", obs_frdy, 0);
    check("t6_pre_err", obs_err, 8'h80);
    bus.rq_in_vld = 2'b11;
    rst = 1'b1;
    #1;
    check("t6_rst_f_in_vld", bus.f_in_vld, 0);
    check("t6_rst_empty", bus.f_out_rdy, 1);
    check("t6_rst_err", err, 0);
    check("t6_rst_ope", bus.f_ope_data, 0);
    check("t6_rst_no_rdy", bus.rq_in_rdy, 0);
    bus.rq_in_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      bus.rq_in_vld = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), $urandom, $urandom);
      bus.f_in_rdy   = ($urandom_range(0, 3) != 0);
      bus.rq_out_rdy = NREQ'($urandom);
      bus.f_out_vld  = (fpu_pending > 0) && ($urandom_range(0, 1) == 1);
      bus.f_out_data = $urandom;
      bus.f_err      = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
